// File: rtl/ddr2_avl_responder.sv
// ddr2_avl_responder: RAM-backed stand-in for the DDR2 controller local (avl_*) port,
// mimicking calibration status, fixed read latency, burst sequencing and ready backpressure.
module ddr2_avl_responder #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 64,
  parameter int BURST_W        = 3,
  parameter int MEM_AW         = 10,
  parameter int INIT_CYCLES    = 5000,
  parameter int RD_LAT         = 4,
  parameter bit FORCE_CAL_FAIL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  avl_ready,
  input  logic                  avl_burstbegin,
  input  logic [ADDR_W-1:0]     avl_addr,
  input  logic [DATA_W-1:0]     avl_wdata,
  input  logic [DATA_W/8-1:0]   avl_be,
  input  logic                  avl_read_req,
  input  logic                  avl_write_req,
  input  logic [BURST_W-1:0]    avl_size,
  output logic [DATA_W-1:0]     avl_rdata,
  output logic                  avl_rdata_valid,
  output logic                  local_init_done,
  output logic                  local_cal_success,
  output logic                  local_cal_fail,
  output logic                  proto_err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int ICNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  // RAM output register counts as the first of RD_LAT-1 internal stages; the
  // output register supplies the last cycle of latency.
  localparam int PIPE_N = RD_LAT - 1;

  localparam logic [ICNT_W-1:0]  INIT_LAST = ICNT_W'(INIT_CYCLES - 1);
  localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);
  localparam logic [MEM_AW-1:0]  ONE_WORD  = MEM_AW'(1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_BURST,
    ST_FAIL
  } state_t;

  state_t              state_reg, state_next;
  logic [ICNT_W-1:0]   init_cnt_reg, init_cnt_next;
  logic [BURST_W-1:0]  beats_reg, beats_next;
  logic [MEM_AW-1:0]   addr_reg, addr_next;
  logic                proto_err_reg, proto_err_next;

  logic                wr_en;
  logic [MEM_AW-1:0]   wr_idx;
  logic                rd_en;
  logic [MEM_AW-1:0]   rd_idx;
  logic [MEM_AW-1:0]   req_idx;
  logic [BURST_W-1:0]  req_len;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   pipe_data [PIPE_N];
  logic [PIPE_N-1:0]   pipe_vld;

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^avl_addr[ADDR_W-1:MEM_AW];

  assign req_idx = avl_addr[MEM_AW-1:0];
  assign req_len = (avl_size == '0) ? ONE_BEAT : avl_size;

  assign local_init_done   = (state_reg == ST_IDLE) || (state_reg == ST_WR_BURST) ||
                             (state_reg == ST_RD_BURST);
  assign local_cal_success = local_init_done;
  assign local_cal_fail    = (state_reg == ST_FAIL);
  assign proto_err         = proto_err_reg;

  always_comb begin
    state_next     = state_reg;
    init_cnt_next  = init_cnt_reg;
    beats_next     = beats_reg;
    addr_next      = addr_reg;
    proto_err_next = proto_err_reg;
    wr_en          = 1'b0;
    wr_idx         = addr_reg;
    rd_en          = 1'b0;
    rd_idx         = addr_reg;
    avl_ready      = 1'b0;

    case (state_reg)
      ST_INIT: begin
        init_cnt_next = init_cnt_reg + ICNT_W'(1);
        if (init_cnt_reg == INIT_LAST) begin
          state_next = FORCE_CAL_FAIL ? ST_FAIL : ST_IDLE;
        end
      end

      ST_IDLE: begin
        avl_ready = 1'b1;
        if (avl_write_req || avl_read_req) begin
          // Any request here starts a burst; malformed starts are still honoured.
          addr_next  = req_idx + ONE_WORD;
          beats_next = req_len - ONE_BEAT;
          if (!avl_burstbegin || (avl_size == '0) || (avl_write_req && avl_read_req)) begin
            proto_err_next = 1'b1;
          end
          if (avl_write_req) begin
            wr_en  = 1'b1;
            wr_idx = req_idx;
            if (req_len != ONE_BEAT) begin
              state_next = ST_WR_BURST;
            end
          end else begin
            rd_en  = 1'b1;
            rd_idx = req_idx;
            if (req_len != ONE_BEAT) begin
              state_next = ST_RD_BURST;
            end
          end
        end
      end

      ST_WR_BURST: begin
        avl_ready = 1'b1;
        if (avl_burstbegin || avl_read_req) begin
          proto_err_next = 1'b1;
        end
        if (avl_write_req) begin
          wr_en      = 1'b1;
          addr_next  = addr_reg + ONE_WORD;
          beats_next = beats_reg - ONE_BEAT;
          if (beats_reg == ONE_BEAT) begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_RD_BURST: begin
        rd_en      = 1'b1;
        addr_next  = addr_reg + ONE_WORD;
        beats_next = beats_reg - ONE_BEAT;
        if (beats_reg == ONE_BEAT) begin
          state_next = ST_IDLE;
        end
      end

      ST_FAIL: begin
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= '0;
      beats_reg     <= '0;
      addr_reg      <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_cnt_reg  <= init_cnt_next;
      beats_reg     <= beats_next;
      addr_reg      <= addr_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // A write lands at the clock edge before any following read samples the
  // array, so a read in the next cycle already sees the new word.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avl_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= avl_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    pipe_data[0] <= mem[rd_idx];
    for (int i = 1; i < PIPE_N; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_en;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // avl_rdata only moves on a valid beat so it holds between bursts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      avl_rdata_valid <= 1'b0;
      avl_rdata       <= '0;
    end else begin
      avl_rdata_valid <= pipe_vld[PIPE_N-1];
      if (pipe_vld[PIPE_N-1]) begin
        avl_rdata <= pipe_data[PIPE_N-1];
      end
    end
  end

endmodule

// File: tb/tb_ddr2_avl_responder.sv
// Bench for ddr2_avl_responder: randomized Avalon traffic against a word-array model
// with an expected-beat queue; a second instance covers forced calibration failure.
module tb_ddr2_avl_responder;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 64;
  localparam int BURST_W     = 3;
  localparam int MEM_AW      = 10;
  localparam int INIT_CYCLES = 5000;
  localparam int RD_LAT      = 4;
  localparam int BE_W        = DATA_W / 8;
  localparam int DEPTH       = 1 << MEM_AW;

  typedef struct {
    int                c;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                avl_burstbegin = 1'b0;
  logic                avl_read_req   = 1'b0;
  logic                avl_write_req  = 1'b0;
  logic [ADDR_W-1:0]   avl_addr  = '0;
  logic [DATA_W-1:0]   avl_wdata = '0;
  logic [BE_W-1:0]     avl_be    = '0;
  logic [BURST_W-1:0]  avl_size  = '0;

  logic                avl_ready, avl_rdata_valid, local_init_done, local_cal_success;
  logic                local_cal_fail, proto_err;
  logic [DATA_W-1:0]   avl_rdata;
  logic                f_ready, f_rdata_valid, f_init_done, f_cal_success, f_cal_fail, f_proto_err;
  logic [DATA_W-1:0]   f_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int c0    = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  beat_t exp_q[$];
  beat_t obs_q[$];

  ddr2_avl_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MEM_AW(MEM_AW),
    .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT), .FORCE_CAL_FAIL(1'b0)
  ) dut (
    .CLK(clk), .RST(rst), .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .proto_err(proto_err)
  );

  ddr2_avl_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MEM_AW(MEM_AW),
    .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT), .FORCE_CAL_FAIL(1'b1)
  ) dut_fail (
    .CLK(clk), .RST(rst), .avl_ready(f_ready), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .avl_rdata(f_rdata), .avl_rdata_valid(f_rdata_valid),
    .local_init_done(f_init_done), .local_cal_success(f_cal_success),
    .local_cal_fail(f_cal_fail), .proto_err(f_proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid beat with the cycle it was seen in.
  always @(negedge clk) begin
    if (avl_rdata_valid === 1'b1) obs_q.push_back('{c: cyc, d: avl_rdata});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_burstbegin = 1'b0;
  endtask

  function automatic void model_write(int idx, logic [DATA_W-1:0] d, logic [BE_W-1:0] be);
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Legal write burst with random data; later beats carry junk addresses.
  task automatic write_burst(input logic [ADDR_W-1:0] a, input int n, input bit rnd_be,
                             input int stall_pct);
    int idx;
    idx = int'(a[MEM_AW-1:0]);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && $urandom_range(99) < stall_pct) begin
        idle_inputs();
        step();
      end
      avl_write_req  = 1'b1;
      avl_burstbegin = (k == 0);
      avl_addr       = (k == 0) ? a : ADDR_W'($urandom);
      avl_size       = BURST_W'(n);
      avl_wdata      = {$urandom, $urandom};
      avl_be         = rnd_be ? BE_W'($urandom) : '1;
      model_write((idx + k) % DEPTH, avl_wdata, avl_be);
      step();
    end
    idle_inputs();
  endtask

  // Read burst: beat k issues at accept+k and is due RD_LAT cycles later.
  task automatic read_burst(input logic [ADDR_W-1:0] a, input int n);
    int idx;
    idx = int'(a[MEM_AW-1:0]);
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = a;
    avl_size       = BURST_W'(n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{c: cyc + k + RD_LAT, d: mem_m[(idx + k) % DEPTH]});
    end
    step();
    idle_inputs();
    avl_addr = ADDR_W'($urandom);
    repeat (n - 1) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    n_cmp++;
    if ({avl_ready, avl_rdata_valid, local_init_done, local_cal_success, local_cal_fail,
         proto_err} !== 6'b0 || avl_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b done=%b ok=%b calf=%b perr=%b rdata=%h, expected all 0",
               avl_ready, avl_rdata_valid, local_init_done, local_cal_success, local_cal_fail,
               proto_err, avl_rdata);
    end
    rst = 1'b0;
    c0 = cyc;
    while (cyc < c0 + INIT_CYCLES - 1) step();
    n_cmp++;
    if (local_init_done !== 1'b0 || avl_ready !== 1'b0 || f_cal_fail !== 1'b0) begin
      n_bad++;
      $display("FAIL init_early: at +%0d got done=%b rdy=%b f_calf=%b, expected 0 0 0",
               cyc - c0, local_init_done, avl_ready, f_cal_fail);
    end
    step();
    n_cmp++;
    if (local_init_done !== 1'b1 || local_cal_success !== 1'b1 || avl_ready !== 1'b1 ||
        local_cal_fail !== 1'b0) begin
      n_bad++;
      $display("FAIL init_done: at +%0d got done=%b ok=%b rdy=%b calf=%b, expected 1 1 1 0",
               cyc - c0, local_init_done, local_cal_success, avl_ready, local_cal_fail);
    end
    n_cmp++;
    if (f_cal_fail !== 1'b1 || f_init_done !== 1'b0 || f_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_fail_rise: at +%0d got calf=%b done=%b rdy=%b, expected 1 0 0",
               cyc - c0, f_cal_fail, f_init_done, f_ready);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < (DEPTH + 6) / 7; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom);
      a[MEM_AW-1:0] = MEM_AW'(i * 7);
      write_burst(a, 7, 1'b0, 0);
    end
  endtask

  task automatic test_wrap_burst();
    logic [DATA_W-1:0] wd [4];
    logic [ADDR_W-1:0] a;
    int ta, last;
    wd[0] = 64'h1111_1111_1111_1111;
    wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333;
    wd[3] = 64'h4444_4444_4444_4444;
    a = ADDR_W'($urandom);
    a[MEM_AW-1:0] = 10'h3FE;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        idle_inputs();
        n_cmp++;
        if (avl_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL wrap_stall_ready: got %b, expected 1", avl_ready);
        end
        step();
      end
      avl_write_req  = 1'b1;
      avl_burstbegin = (k == 0);
      avl_addr       = (k == 0) ? a : ADDR_W'($urandom);
      avl_size       = 3'd4;
      avl_wdata      = wd[k];
      avl_be         = '1;
      model_write((10'h3FE + k) % DEPTH, wd[k], '1);
      step();
    end
    idle_inputs();
    a = ADDR_W'($urandom);
    a[MEM_AW-1:0] = 10'h3FE;
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = a;
    avl_size       = 3'd4;
    ta = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back('{c: ta + 4 + k, d: wd[k]});
    n_cmp++;
    if (avl_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_accept_ready: got %b, expected 1", avl_ready);
    end
    step();
    idle_inputs();
    for (int j = 1; j <= 3; j++) begin
      n_cmp++;
      if (avl_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap_busy_ready: at accept+%0d got %b, expected 0", j, avl_ready);
      end
      step();
    end
    n_cmp++;
    if (avl_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_ready_back: at accept+4 got %b, expected 1", avl_ready);
    end
    last = exp_q[exp_q.size()-1].c;
    while (cyc < last + 2) step();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        n_bad++;
        $display("FAIL wrap_beat%0d: got cyc %0d data %h, expected cyc %0d data %h",
                 i, obs_q[i].c, obs_q[i].d, exp_q[i].c, exp_q[i].d);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (avl_rdata_valid !== 1'b0 || avl_rdata !== wd[3]) begin
      n_bad++;
      $display("FAIL rdata_hold: got vld=%b data %h, expected 0 %h", avl_rdata_valid, avl_rdata, wd[3]);
    end
  endtask

  task automatic test_byte_enable();
    logic [ADDR_W-1:0] a;
    int last;
    a = ADDR_W'($urandom);
    a[MEM_AW-1:0] = 10'd5;
    avl_write_req = 1'b1; avl_burstbegin = 1'b1; avl_addr = a; avl_size = 3'd1;
    avl_wdata = '1; avl_be = '1;
    model_write(5, avl_wdata, avl_be);
    step();
    avl_wdata = '0; avl_be = BE_W'(8'h0F);
    model_write(5, avl_wdata, avl_be);
    step();
    idle_inputs();
    avl_read_req = 1'b1; avl_burstbegin = 1'b1; avl_addr = a; avl_size = 3'd1;
    exp_q.push_back('{c: cyc + RD_LAT, d: 64'hFFFF_FFFF_0000_0000});
    step();
    idle_inputs();
    last = exp_q[exp_q.size()-1].c;
    while (cyc < last + 2) step();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL be_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        n_bad++;
        $display("FAIL be_beat%0d: got cyc %0d data %h, expected cyc %0d data %h",
                 i, obs_q[i].c, obs_q[i].d, exp_q[i].c, exp_q[i].d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    int last;
    for (int k = 0; k < 8; k++) begin
      a = ADDR_W'($urandom);
      a[MEM_AW-1:0] = MEM_AW'(k);
      avl_read_req = 1'b1; avl_burstbegin = 1'b1; avl_addr = a; avl_size = 3'd1;
      exp_q.push_back('{c: cyc + RD_LAT, d: mem_m[k]});
      n_cmp++;
      if (avl_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready%0d: got %b, expected 1", k, avl_ready);
      end
      step();
    end
    idle_inputs();
    last = exp_q[exp_q.size()-1].c;
    while (cyc < last + 2) step();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got cyc %0d data %h, expected cyc %0d data %h",
                 i, obs_q[i].c, obs_q[i].d, exp_q[i].c, exp_q[i].d);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random_traffic();
    int last;
    for (int it = 0; it < 60; it++) begin
      logic [ADDR_W-1:0] a;
      int n;
      a = ADDR_W'($urandom);
      n = $urandom_range(1, 7);
      if ($urandom_range(1) == 1) write_burst(a, n, 1'b1, 30);
      else read_burst(a, n);
      if ($urandom_range(3) == 0) step();
    end
    last = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].c : cyc;
    while (cyc < last + 2) step();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d beats, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        n_bad++;
        $display("FAIL rand_beat%0d: got cyc %0d data %h, expected cyc %0d data %h",
                 i, obs_q[i].c, obs_q[i].d, exp_q[i].c, exp_q[i].d);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rand_proto_err: got %b after legal traffic, expected 0", proto_err);
    end
  endtask

  task automatic test_both_req();
    logic [ADDR_W-1:0] a;
    int last;
    a = ADDR_W'($urandom);
    avl_read_req = 1'b1; avl_write_req = 1'b1; avl_burstbegin = 1'b1;
    avl_addr = a; avl_size = 3'd1; avl_wdata = {$urandom, $urandom}; avl_be = '1;
    model_write(int'(a[MEM_AW-1:0]), avl_wdata, avl_be);
    step();
    idle_inputs();
    repeat (RD_LAT + 3) step();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL both_no_read: got %0d beats, expected 0", obs_q.size());
    end
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL both_proto_err: got %b, expected 1", proto_err);
    end
    obs_q.delete();
    read_burst(a, 1);
    last = exp_q[exp_q.size()-1].c;
    while (cyc < last + 2) step();
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0].c !== exp_q[0].c || obs_q[0].d !== exp_q[0].d) begin
      n_bad++;
      $display("FAIL both_write_data: got %0d beats first %h, expected 1 beat %h at cyc %0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].d : '0, exp_q[0].d, exp_q[0].c);
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL proto_err_sticky: got %b, expected 1", proto_err);
    end
  endtask

  task automatic test_cal_fail_hold();
    int bad_cycles = 0;
    while (cyc < c0 + INIT_CYCLES + 10000) begin
      if (f_cal_fail !== 1'b1 || f_init_done !== 1'b0 || f_ready !== 1'b0 ||
          f_cal_success !== 1'b0) bad_cycles++;
      step();
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL cal_fail_hold: got %0d cycles off calf=1/done=0/rdy=0, expected 0", bad_cycles);
    end
  endtask

  task automatic test_reset_mid_burst();
    int c1;
    avl_read_req = 1'b1; avl_burstbegin = 1'b1; avl_addr = ADDR_W'($urandom); avl_size = 3'd4;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    n_cmp++;
    if (avl_rdata_valid !== 1'b0 || avl_ready !== 1'b0 || proto_err !== 1'b0 ||
        local_init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got vld=%b rdy=%b perr=%b done=%b, expected 0 0 0 0",
               avl_rdata_valid, avl_ready, proto_err, local_init_done);
    end
    repeat (3) step();
    rst = 1'b0;
    c1 = cyc;
    repeat (8) step();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_flush: got %0d beats after reset, expected 0", obs_q.size());
    end
    obs_q.delete();
    while (cyc < c1 + INIT_CYCLES - 1) step();
    n_cmp++;
    if (local_init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reinit_early: got done=%b, expected 0", local_init_done);
    end
    step();
    n_cmp++;
    if (local_init_done !== 1'b1 || avl_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reinit_done: got done=%b rdy=%b, expected 1 1", local_init_done, avl_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap_burst();
    test_byte_enable();
    test_back_to_back();
    test_random_traffic();
    test_both_req();
    test_cal_fail_hold();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
